// File: rtl/mem_pkg.sv
// Shared types and widths for the memory access stage.
// State encoding and counter width used by the controller and its wait counter.
package mem_pkg;

  localparam int MEM_ADDR_W = 9;
  localparam int MEM_DATA_W = 32;
  localparam int WAIT_CTR_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_wait_ctr.sv
// Loadable down-counter that times the ACCESS dwell. Latency: load/decrement visible next cycle.
// Backpressure: none; it saturates at zero and zero_o flags the final access cycle.
module mem_wait_ctr
  import mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  load_i,
  input  logic [WAIT_CTR_W-1:0] load_val_i,
  input  logic                  dec_i,
  output logic                  zero_o
);

  logic [WAIT_CTR_W-1:0] cnt_q;
  logic [WAIT_CTR_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-side stage: runs one read/write on a single-port RAM with programmable wait states, owns the MDR.
// Latency: done pulses WAIT_STATES+2 cycles after the request cycle; requests during ACCESS are dropped.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W      = MEM_DATA_W,
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mdr_en,
  input  logic              read,
  input  logic              write,
  output logic [DATA_W-1:0] mdr_out,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);

  if ((WAIT_STATES < 0) || (WAIT_STATES > 15)) begin : g_bad_wait_states
    $fatal(1, "mem_access_ctrl: WAIT_STATES must be 0..15");
  end

  localparam logic [WAIT_CTR_W-1:0] WAIT_LD = WAIT_CTR_W'(WAIT_STATES);

  mem_state_e        state_q, state_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              is_wr_q, is_wr_d;
  logic              ctr_load;
  logic              ctr_dec;
  logic              ctr_zero;
  logic              req;
  logic              accept;

  assign req    = read | write;
  assign accept = req && ((state_q == IDLE) || (state_q == DONE));

  always_comb begin
    state_d  = state_q;
    mdr_d    = mdr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    is_wr_d  = is_wr_q;
    ctr_load = 1'b0;
    ctr_dec  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!req && mdr_en) begin
          mdr_d = bus_in;
        end
      end
      ACCESS: begin
        ctr_dec = 1'b1;
        if (ctr_zero) begin
          state_d = DONE;
          if (!is_wr_q) begin
            mdr_d = ram_rdata;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Write wins when both strobes arrive together; write data is the pre-edge MDR.
    if (accept) begin
      state_d  = ACCESS;
      addr_d   = addr_in;
      is_wr_d  = write;
      ctr_load = 1'b1;
      if (write) begin
        wdata_d = mdr_q;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      mdr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mdr_q   <= mdr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
    end
  end

  mem_wait_ctr u_wait_ctr (
    .clk        (clk),
    .clr_n      (clr_n),
    .load_i     (ctr_load),
    .load_val_i (WAIT_LD),
    .dec_i      (ctr_dec),
    .zero_o     (ctr_zero)
  );

  assign mdr_out   = mdr_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign busy      = (state_q == ACCESS);
  assign done      = (state_q == DONE);
  assign ram_we    = (state_q == ACCESS) && is_wr_q && ctr_zero;

endmodule
